// File: rtl/decoder_pkg.sv
// Shared types and constants for the registered one-hot decoder family.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_nx_prescaler.sv
// Scan dwell prescaler: counts clocks while running and ticks once per div+1 clocks.
module scan_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // The >= compare lets div shrink below the current count without overrunning.
  assign tick = run && (cnt >= div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/decoder_scan_nx.sv
// Registered binary-to-one-hot decoder with direct-load and auto-scan modes,
// out-of-range detection and a wrap pulse for downstream sync.
module decoder_scan_nx
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DIV_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic               load,
  input  logic [DIV_W-1:0]   div,
  output logic [NUM_OUT-1:0] d,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap,
  output logic               err
);

  // One extra bit so NUM_OUT == 2**SEL_W is representable.
  localparam logic [SEL_W:0]   NUM_OUT_V = (SEL_W+1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_OUT - 1);

  function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [NUM_OUT-1:0] oh;
    for (int k = 0; k < NUM_OUT; k++) oh[k] = (i == SEL_W'(k));
    return oh;
  endfunction

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   idx_nxt;
  logic [NUM_OUT-1:0] d_nxt;
  logic               wrap_nxt, err_nxt;
  logic               sel_ok, run, tick;

  assign sel_ok = ({1'b0, sel_in} < NUM_OUT_V);
  assign run    = (state == ST_SCAN) && en && (mode == MODE_SCAN);

  // Counter is held at zero whenever the scan is not actively running,
  // which also gives the cnt = 0 entry condition for free.
  scan_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!run),
    .run   (run),
    .div   (div),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      d     <= '0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      d     <= d_nxt;
      wrap  <= wrap_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_nxt   = err;
    wrap_nxt  = 1'b0;

    if (!en) begin
      state_nxt = ST_IDLE;
      err_nxt   = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DIRECT, ST_SCAN: begin
          // Mode entry (from IDLE or a mode change) takes priority over load/tick.
          if (mode == MODE_DIRECT && state != ST_DIRECT) begin
            state_nxt = ST_DIRECT;
            idx_nxt   = sel_ok ? sel_in : '0;
            err_nxt   = !sel_ok;
          end else if (mode == MODE_SCAN && state != ST_SCAN) begin
            state_nxt = ST_SCAN;
            idx_nxt   = '0;
            err_nxt   = 1'b0;
          end else if (state == ST_DIRECT) begin
            if (load) begin
              if (sel_ok) idx_nxt = sel_in;
              err_nxt = !sel_ok;
            end
          end else if (tick) begin
            if (idx == LAST_IDX) begin
              idx_nxt  = '0;
              wrap_nxt = 1'b1;
            end else begin
              idx_nxt = idx + SEL_W'(1);
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    d_nxt = (state_nxt != ST_IDLE) ? onehot(idx_nxt) : '0;
  end

endmodule

// File: tb/tb_decoder_scan_nx.sv
// Randomized and directed bench for decoder_scan_nx: an 8-output and a 6-output
// instance share stimulus and are checked against a behavioural model.
module tb_decoder_scan_nx;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, load;
  logic [2:0] sel_in;
  logic [7:0] div;

  logic [7:0] d8;
  logic [5:0] d6;
  logic [2:0] idx8, idx6;
  logic       wrap8, wrap6, err8, err6;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: st 0 = idle, 1 = direct, 2 = scan
  int nout[2] = '{8, 6};
  int m_st[2], m_idx[2], m_cnt[2], m_err[2], m_wrap[2];

  decoder_scan_nx #(.SEL_W(3), .NUM_OUT(8), .DIV_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
    .load(load), .div(div), .d(d8), .idx(idx8), .wrap(wrap8), .err(err8)
  );

  decoder_scan_nx #(.SEL_W(3), .NUM_OUT(6), .DIV_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
    .load(load), .div(div), .d(d6), .idx(idx6), .wrap(wrap6), .err(err6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_idx[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int n;
    n = nout[k];
    m_wrap[k] = 0;
    if (!en) begin
      m_st[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
    end else if (m_st[k] == 0 || (mode ? (m_st[k] != 2) : (m_st[k] != 1))) begin
      m_cnt[k] = 0;
      if (!mode) begin
        m_st[k] = 1;
        if (int'(sel_in) < n) begin m_idx[k] = int'(sel_in); m_err[k] = 0; end
        else begin m_idx[k] = 0; m_err[k] = 1; end
      end else begin
        m_st[k] = 2; m_idx[k] = 0; m_err[k] = 0;
      end
    end else if (m_st[k] == 1) begin
      if (load) begin
        if (int'(sel_in) < n) begin m_idx[k] = int'(sel_in); m_err[k] = 0; end
        else m_err[k] = 1;
      end
    end else begin
      if (m_cnt[k] >= int'(div)) begin
        m_cnt[k] = 0;
        if (m_idx[k] == n - 1) begin m_idx[k] = 0; m_wrap[k] = 1; end
        else m_idx[k] = m_idx[k] + 1;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  function automatic logic [31:0] exp_d(input int k);
    return (m_st[k] != 0) ? (32'd1 << m_idx[k]) : 32'd0;
  endfunction

  task automatic compare_all();
    check("d8",    d8,    exp_d(0));
    check("idx8",  idx8,  m_idx[0]);
    check("wrap8", wrap8, m_wrap[0]);
    check("err8",  err8,  m_err[0]);
    check("d6",    d6,    exp_d(1));
    check("idx6",  idx6,  m_idx[1]);
    check("wrap6", wrap6, m_wrap[1]);
    check("err6",  err6,  m_err[1]);
  endtask

  // One clock: model advances on the same edge, outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin model_step(0); model_step(1); end
    #1;
    compare_all();
  endtask

  initial begin
    int c;
    int prev;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; sel_in = '0; div = '0;
    model_reset();

    // Reset and enable-low
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (2) cycle();
    check("idle_d8", d8, 32'h0);

    // DIRECT entry, load, disable
    en = 1'b1; mode = 1'b0; sel_in = 3'd5;
    cycle();
    check("direct_entry", d8, 32'h20);
    load = 1'b1; sel_in = 3'd2;
    cycle();
    check("direct_load", d8, 32'h04);
    load = 1'b0; en = 1'b0;
    cycle();
    check("disable_d", d8, 32'h0);
    check("disable_idx", idx8, 32'd2);

    // Out-of-range on the 6-output instance
    en = 1'b1; sel_in = 3'd3;
    cycle();
    load = 1'b1; sel_in = 3'd7;
    cycle();
    check("oor_err6", err6, 32'd1);
    check("oor_d6", d6, 32'h08);
    sel_in = 3'd3;
    cycle();
    check("oor_clear6", err6, 32'd0);
    check("oor_d6b", d6, 32'h08);
    load = 1'b0;

    // SCAN div=2: full sweep is 24 clocks
    mode = 1'b1; div = 8'd2;
    cycle();
    check("scan_entry", d8, 32'h01);
    c = 0;
    do begin cycle(); c++; end while (!wrap8 && c < 100);
    check("sweep_len", c, 24);
    cycle();
    check("wrap_one_cycle", wrap8, 32'd0);

    // SCAN div=0, then widen and narrow mid-count
    mode = 1'b0; cycle();
    mode = 1'b1; div = 8'd0; cycle();
    repeat (5) cycle();
    div = 8'd4;
    repeat (12) cycle();
    c = 0;
    while (m_cnt[0] != 3 && c < 20) begin cycle(); c++; end
    check("cnt_reach", m_cnt[0], 3);
    prev = m_idx[0];
    div = 8'd1;
    cycle();
    check("no_overrun", idx8, (prev + 1) % 8);
    repeat (4) cycle();

    // Mode switches
    div = 8'd0;
    c = 0;
    while (m_idx[0] != 6 && c < 20) begin cycle(); c++; end
    check("reach_idx6", idx8, 32'd6);
    mode = 1'b0; sel_in = 3'd1;
    cycle();
    check("sw_direct", d8, 32'h02);
    mode = 1'b1;
    cycle();
    check("sw_scan", d8, 32'h01);

    // Async reset mid-dwell
    div = 8'd3;
    repeat (2) cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_d8", d8, 32'h0);
    check("async_d6", d6, 32'h0);
    check("async_idx8", idx8, 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (3) cycle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst_n  = ($urandom_range(199) != 0);
      en     = ($urandom_range(19) != 0);
      if ($urandom_range(14) == 0) mode = ~mode;
      load   = ($urandom_range(2) == 0);
      sel_in = 3'($urandom_range(7));
      if ($urandom_range(24) == 0) div = 8'($urandom_range(3));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
